q2_panel: RTL and testbench
===========================

# q2_panel

Front-panel controller for the q2 machine. Debounces the raw panel switches and turns them into single-cycle events. Owns the run/stop/single-step state machine, and performs deposit/examine memory cycles through a request/acknowledge port. Sits between the panel switches and the q2 core/memory, replacing ad-hoc start/stop/halt latching. It is parametrised in datapath width and debounce length.

## Interface
Parameters:
- WIDTH, 12, data/address width of switches, panel address and memory port
- DEBOUNCE, 16, consecutive stable cycles required before a switch change is accepted (≥1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- sw  in  WIDTH  raw data/address switches (sampled through 2-flop sync, not debounced)
- ld_sw, dep_sw, exam_sw, incp_sw, start_sw, stop_sw, step_sw  in  1 each  raw momentary switches, active-high
- halt_req  in  1  core halt detect (e.g. "jmp $"), level
- instr_done  in  1  one-cycle pulse from core at each completed instruction
- run  out  1  core enable
- halted  out  1  sticky: last stop caused by halt_req
- busy  out  1  panel memory cycle in progress
- pa  out  WIDTH  panel address register
- display  out  WIDTH  last examined/deposited word
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  WIDTH  equals pa while mem_req
- mem_wdata  out  WIDTH  data captured from sw at request start
- mem_rdata  in  WIDTH  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

## Operation
- Per switch: a 2-flop synchroniser feeds a counter. The counter counts cycles where the synced value ≠ debounced state and clears when they agree. At DEBOUNCE the debounced state flips. A 0→1 flip produces a one-cycle event.
- States: IDLE, RUN, STOPPING, STEP, MEMRD, MEMWR.
- IDLE: run=0. Event priority when several arrive in the same cycle: stop > start > step > dep > exam > ld > incp. Only the highest-priority event is acted on; the others are dropped.
  - start → RUN and clear halted.
  - step → STEP and clear halted.
  - dep → MEMWR with mem_wdata←sw.
  - exam → MEMRD.
  - ld → pa←sw.
  - incp → pa←pa+1.
  - stop in IDLE is a no-op.
- RUN: run=1.
  - halt_req → IDLE, run=0, halted=1, taking priority over stop.
  - stop → STOPPING.
- STOPPING: run=1 until instr_done, then IDLE. halt_req → IDLE with halted=1.
- STEP: run=1 until the first instr_done, then IDLE. halt_req → IDLE with halted=1.
- MEMWR/MEMRD: mem_req=1 and busy=1.
  - On mem_ack: MEMWR loads display←mem_wdata; MEMRD loads display←mem_rdata.
  - Then return to IDLE. Post-increment of pa is controlled by the macro under Configuration.
- All panel events other than stop arriving outside IDLE are discarded, not queued. stop is also discarded in STOPPING, STEP, MEMRD and MEMWR.
- pa arithmetic is modulo 2^WIDTH: all-ones + 1 = 0.

## Timing
- Reset values: run=0, halted=0, busy=0, pa=0, display=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. All debounced states and counters are 0. State is IDLE.
- Reset asserted mid-operation forces reset values immediately (asynchronous). mem_req drops without waiting for ack.
- Event latency: raw high sampled at edge N → event high during the cycle after edge N+1+DEBOUNCE. Release requires the same DEBOUNCE cycles.
- A glitch shorter than DEBOUNCE cycles produces no event.
- Registered outputs:
  - run rises the cycle after the start/step event.
  - run falls the cycle after halt_req or instr_done.
- mem_req rises the cycle after the dep/exam event. mem_addr, mem_we and mem_wdata are stable until ack.
- mem_ack in the same cycle mem_req rises is legal. Any mem_ack seen while not in MEMRD/MEMWR is ignored.
- Throughput: at most one memory cycle in flight.

## Configuration
- Q2_PANEL_AUTOINC_EN defined: after mem_ack in MEMWR or MEMRD, pa←pa+1 in the same cycle display updates. This gives PDP-style sequential deposit/examine.
- Q2_PANEL_AUTOINC_EN undefined: pa is unchanged by deposit/examine; only ld and incp modify pa.

## Test plan
All scenarios use WIDTH=12 and DEBOUNCE=4.
- Debounce: pulse dep_sw high for 3 cycles → no mem_req. Hold it for 10 cycles → exactly one mem_req; no second request on release.
- Load/deposit/examine (AUTOINC_EN):
  - ld with sw=0x0FF, then dep with sw=0xA5A → write to 0x0FF with wdata 0xA5A, ack after 2 cycles → pa=0x100, display=0xA5A.
  - ld sw=0x0FF, then exam with rdata=0xA5A → display=0xA5A, pa=0x100.
- Wrap: ld sw=0xFFF, then incp → pa=0x000. Repeat without AUTOINC_EN: dep leaves pa=0xFFF.
- Run/stop: start → run=1. stop, then instr_done 5 cycles later → run stays 1 for those 5 cycles, falls the cycle after instr_done, halted=0.
- Halt/step:
  - In RUN, raise halt_req → run=0 next cycle, halted=1.
  - step → run=1 for exactly one instr_done, then 0; halted cleared.
  - dep during RUN → no mem_req.
- Reset mid-cycle: assert rst low while mem_req=1 with no ack → mem_req=0 and pa=0 immediately. A later mem_ack is ignored.

Source files
------------

// File: rtl/q2_panel.sv
// q2_panel: front-panel controller for the q2 machine.
//
// Debounces the raw panel switches into single-cycle events, runs the
// run/stop/single-step state machine, and performs deposit/examine memory
// cycles through a request/acknowledge port.
//
// Parameters:
//   WIDTH     data/address width of switches, panel address and memory port
//   DEBOUNCE  consecutive stable cycles before a switch change is accepted (>=1)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   sw                       raw data/address switches (2-flop synced only)
//   ld_sw .. step_sw         raw momentary switches, active-high
//   halt_req, instr_done     core halt detect (level), instruction-done pulse
//   run, halted, busy        core enable, sticky halt flag, memory cycle active
//   pa, display              panel address, last examined/deposited word
//   mem_req/we/addr/wdata    memory request port, held until mem_ack
//   mem_rdata, mem_ack       read data and one-cycle completion strobe
//
// Configuration macro:
//   Q2_PANEL_AUTOINC_EN  when defined, pa post-increments on every completed
//                        deposit/examine; otherwise only ld/incp change pa.

// One switch: 2-flop synchroniser, run-length counter, rising-edge pulse.
module q2_panel_db #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          meta, sync, level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            pulse <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // DEBOUNCE-th disagreeing cycle: accept the new level
                level <= sync;
                cnt   <= '0;
                pulse <= sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module q2_panel #(
    parameter int WIDTH    = 12,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             ld_sw,
    input  logic             dep_sw,
    input  logic             exam_sw,
    input  logic             incp_sw,
    input  logic             start_sw,
    input  logic             stop_sw,
    input  logic             step_sw,
    input  logic             halt_req,
    input  logic             instr_done,
    output logic             run,
    output logic             halted,
    output logic             busy,
    output logic [WIDTH-1:0] pa,
    output logic [WIDTH-1:0] display,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);
`ifdef Q2_PANEL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    // Event bit order is also the IDLE priority order (bit 0 wins).
    localparam int NSW = 7;
    localparam int E_STOP = 0, E_START = 1, E_STEP = 2, E_DEP = 3,
                   E_EXAM = 4, E_LD = 5, E_INCP = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_STOPPING, S_STEP, S_MEMRD, S_MEMWR
    } state_t;

    logic [NSW-1:0]   raw, ev;
    logic [WIDTH-1:0] sw_meta, sw_sync;
    state_t           state_q, state_d;
    logic             pa_ld, pa_inc, wdata_cap, disp_ld, halt_set, halt_clr;
    logic [WIDTH-1:0] disp_val;

    assign raw = {incp_sw, ld_sw, exam_sw, dep_sw, step_sw, start_sw, stop_sw};

    for (genvar i = 0; i < NSW; i++) begin : g_db
        q2_panel_db #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .pulse (ev[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Events outside IDLE fall through unhandled, i.e. are discarded.
    always_comb begin
        state_d   = state_q;
        pa_ld     = 1'b0;
        pa_inc    = 1'b0;
        wdata_cap = 1'b0;
        disp_ld   = 1'b0;
        disp_val  = mem_wdata;
        halt_set  = 1'b0;
        halt_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev[E_STOP]) begin
                    state_d = S_IDLE;
                end else if (ev[E_START]) begin
                    state_d  = S_RUN;
                    halt_clr = 1'b1;
                end else if (ev[E_STEP]) begin
                    state_d  = S_STEP;
                    halt_clr = 1'b1;
                end else if (ev[E_DEP]) begin
                    state_d   = S_MEMWR;
                    wdata_cap = 1'b1;
                end else if (ev[E_EXAM]) begin
                    state_d = S_MEMRD;
                end else if (ev[E_LD]) begin
                    pa_ld = 1'b1;
                end else if (ev[E_INCP]) begin
                    pa_inc = 1'b1;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d  = S_IDLE;
                    halt_set = 1'b1;
                end else if (ev[E_STOP]) begin
                    state_d = S_STOPPING;
                end
            end
            S_STOPPING, S_STEP: begin
                if (halt_req) begin
                    state_d  = S_IDLE;
                    halt_set = 1'b1;
                end else if (instr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_MEMWR, S_MEMRD: begin
                if (mem_ack) begin
                    state_d  = S_IDLE;
                    disp_ld  = 1'b1;
                    disp_val = (state_q == S_MEMRD) ? mem_rdata : mem_wdata;
                    pa_inc   = AUTOINC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pa        <= '0;
            display   <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            if (pa_ld)         pa <= sw_sync;
            else if (pa_inc)   pa <= pa + WIDTH'(1);
            if (disp_ld)       display <= disp_val;
            if (wdata_cap)     mem_wdata <= sw_sync;
            if (halt_set)      halted <= 1'b1;
            else if (halt_clr) halted <= 1'b0;
        end
    end

    // All outputs decode straight from registered state.
    assign run      = (state_q == S_RUN) || (state_q == S_STOPPING) || (state_q == S_STEP);
    assign mem_req  = (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_we   = (state_q == S_MEMWR);
    assign busy     = mem_req;
    assign mem_addr = pa;
endmodule

// File: tb/tb_q2_panel.sv
// tb_q2_panel: directed self-checking bench for q2_panel (WIDTH=12,
// DEBOUNCE=4). Button vector bit order: 0 ld, 1 dep, 2 exam, 3 incp,
// 4 start, 5 stop, 6 step. A background responder acks memory requests
// two cycles after they appear while ack_en is set.
module tb_q2_panel;
    localparam int W = 12;
    localparam int D = 4;
    localparam int B_LD = 0, B_DEP = 1, B_EXAM = 2, B_INCP = 3,
                   B_START = 4, B_STOP = 5, B_STEP = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sw = '0;
    logic [6:0]   btn = '0;
    logic         halt_req = 1'b0, instr_done = 1'b0;
    logic         run, halted, busy, mem_req, mem_we;
    logic [W-1:0] pa, display, mem_addr, mem_wdata;
    logic [W-1:0] mem_rdata = '0;
    logic         mem_ack;

    int n_chk = 0, n_err = 0;
    int req_cnt = 0;
    bit ack_en = 1'b1, man_ack = 1'b0;
    logic         seen_we;
    logic [W-1:0] seen_addr, seen_wdata;

    q2_panel #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .ld_sw(btn[B_LD]), .dep_sw(btn[B_DEP]), .exam_sw(btn[B_EXAM]),
        .incp_sw(btn[B_INCP]), .start_sw(btn[B_START]), .stop_sw(btn[B_STOP]),
        .step_sw(btn[B_STEP]),
        .halt_req(halt_req), .instr_done(instr_done),
        .run(run), .halted(halted), .busy(busy), .pa(pa), .display(display),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory responder: counts request rising edges, acks after 2 cycles.
    initial begin
        logic req_prev;
        int   wcnt;
        req_prev = 1'b0;
        wcnt     = 0;
        mem_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !req_prev) begin
                req_cnt++;
                wcnt = 0;
            end
            req_prev = mem_req;
            if (ack_en) begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (wcnt == 2) mem_ack = 1'b1;
                    wcnt++;
                end
            end else begin
                mem_ack = man_ack;
            end
        end
    end

    task automatic snoop();
        if (mem_req) begin
            seen_we    = mem_we;
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
        end
    endtask

    // Hold a button long enough to debounce, then release it the same way.
    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (14) begin @(negedge clk); snoop(); end
        btn[idx] = 1'b0;
        repeat (14) begin @(negedge clk); snoop(); end
    endtask

    initial begin
        int  rc;
        bit  got_req;
        logic run_held;

        repeat (2) @(negedge clk);
        // reset state
        chk("rst_run", run, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pa", pa, 0);
        chk("rst_display", display, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // glitch of 3 cycles < DEBOUNCE: nothing happens
        btn[B_DEP] = 1'b1;
        repeat (3) @(negedge clk);
        btn[B_DEP] = 1'b0;
        repeat (14) @(negedge clk);
        chk("glitch_no_req", req_cnt, 0);
        chk("glitch_busy", busy, 0);

        // load then deposit
        sw = 12'h0FF;
        press(B_LD);
        chk("ld_pa", pa, 12'h0FF);
        sw = 12'hA5A;
        rc = req_cnt;
        btn[B_DEP] = 1'b1;
        repeat (14) begin @(negedge clk); snoop(); end
        chk("dep_one_req", req_cnt, rc + 1);
        btn[B_DEP] = 1'b0;
        repeat (14) begin @(negedge clk); snoop(); end
        chk("dep_no_req_on_release", req_cnt, rc + 1);
        chk("dep_we", seen_we, 1);
        chk("dep_addr", seen_addr, 12'h0FF);
        chk("dep_wdata", seen_wdata, 12'hA5A);
        chk("dep_display", display, 12'hA5A);
`ifdef Q2_PANEL_AUTOINC_EN
        chk("dep_pa", pa, 12'h100);
`else
        chk("dep_pa", pa, 12'h0FF);
`endif

        // examine
        sw = 12'h0FF;
        press(B_LD);
        mem_rdata = 12'h3C3;
        rc = req_cnt;
        press(B_EXAM);
        chk("exam_one_req", req_cnt, rc + 1);
        chk("exam_we", seen_we, 0);
        chk("exam_addr", seen_addr, 12'h0FF);
        chk("exam_display", display, 12'h3C3);
`ifdef Q2_PANEL_AUTOINC_EN
        chk("exam_pa", pa, 12'h100);
`else
        chk("exam_pa", pa, 12'h0FF);
`endif

        // pa wrap
        sw = 12'hFFF;
        press(B_LD);
        chk("wrap_ld", pa, 12'hFFF);
        press(B_INCP);
        chk("wrap_incp", pa, 12'h000);
        press(B_LD);
        sw = 12'h123;
        press(B_DEP);
        chk("wrap_dep_display", display, 12'h123);
`ifdef Q2_PANEL_AUTOINC_EN
        chk("wrap_dep_pa", pa, 12'h000);
`else
        chk("wrap_dep_pa", pa, 12'hFFF);
`endif

        // run / stop
        press(B_START);
        chk("start_run", run, 1);
        chk("start_halted", halted, 0);
        press(B_STOP);
        chk("stopping_run", run, 1);
        run_held = 1'b1;
        repeat (5) begin @(negedge clk); run_held &= run; end
        chk("stopping_hold5", run_held, 1);
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
        chk("stop_run_fall", run, 0);
        chk("stop_halted", halted, 0);

        // halt, dep ignored while running
        press(B_START);
        rc = req_cnt;
        press(B_DEP);
        chk("run_dep_no_req", req_cnt, rc);
        chk("run_dep_still_run", run, 1);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("halt_run", run, 0);
        chk("halt_halted", halted, 1);

        // single step
        press(B_STEP);
        chk("step_run", run, 1);
        chk("step_halted_clr", halted, 0);
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
        chk("step_run_fall", run, 0);
        repeat (3) @(negedge clk);
        chk("step_stays_idle", run, 0);

        // reset mid memory cycle
        sw = 12'h055;
        press(B_LD);
        chk("pre_rst_pa", pa, 12'h055);
        ack_en = 1'b0;
        btn[B_DEP] = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 30 && !got_req; i++) begin
            @(negedge clk);
            got_req = mem_req;
        end
        chk("rst_mid_req_seen", got_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_pa", pa, 0);
        chk("rst_mid_busy", busy, 0);
        btn[B_DEP] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 man_ack = 1'b1;
        @(posedge clk); #1 man_ack = 1'b1;
        @(posedge clk); #1 man_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_display", display, 0);
        chk("late_ack_pa", pa, 0);
        chk("late_ack_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
